// File: rtl/alu_pkg.sv
// Shared types for the ALU command issuer: opcodes, issuer states, command payload
// and a reference model of the 2-bit ALU.
package alu_pkg;

   localparam int unsigned CMD_WIDTH = 2;

   typedef enum logic [1:0] {
      ADD    = 2'd0,
      SUB    = 2'd1,
      INV    = 2'd2,
      RED_OR = 2'd3
   } opcode_e;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_RESPOND = 2'd2
   } issuer_state_e;

   typedef struct packed {
      opcode_e                op;
      logic [CMD_WIDTH-1:0]   a;
      logic [CMD_WIDTH-1:0]   b;
   } cmd_t;

   // Expected ALU output for a given opcode and operands
   function automatic logic [CMD_WIDTH-1:0] alu_ref(input opcode_e              op,
                                                    input logic [CMD_WIDTH-1:0] a,
                                                    input logic [CMD_WIDTH-1:0] b);
      logic [CMD_WIDTH-1:0] r;
      r = '0;
      case (op)
         ADD:     r = a + b;
         SUB:     r = a - b;
         INV:     r = ~a;
         RED_OR:  r = CMD_WIDTH'(|b);
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command request and response channels between a requester (master) and the
// ALU command issuer (slave).
interface alu_cmd_issuer_if;

   logic                            cmd_valid;
   logic                            cmd_ready;
   logic [1:0]                      cmd_op;
   logic [alu_pkg::CMD_WIDTH-1:0]   cmd_a;
   logic [alu_pkg::CMD_WIDTH-1:0]   cmd_b;
   logic                            rsp_valid;
   logic                            rsp_ready;
   logic [1:0]                      rsp_op;
   logic [alu_pkg::CMD_WIDTH-1:0]   rsp_result;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_op, rsp_result
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
      output cmd_ready, rsp_valid, rsp_op, rsp_result
   );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  cmd_t                     wdata,
   input  logic                     pop,
   output cmd_t                     rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   cmd_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Pointers and occupancy; a simultaneous push and pop leaves count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU requests, issues them one at a time on registered lines and returns
// results in order. Optional result checker enabled by ALU_CMD_ISSUER_CHECK_EN.
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_cmd_issuer_if.slave      bus,
   output logic [1:0]           alu_opcode,
   output logic [WIDTH-1:0]     alu_a,
   output logic [WIDTH-1:0]     alu_b,
   input  logic [WIDTH-1:0]     alu_result,
   output logic                 busy,
   output logic [7:0]           done_cnt,
   output logic                 chk_err
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   issuer_state_e   state;
   issuer_state_e   state_n;
   logic            push_c;
   logic            pop_c;
   logic            capture_c;
   logic            rsp_hs_c;
   cmd_t            fifo_wdata;
   cmd_t            fifo_rdata;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic [CW-1:0]   occ_n;

   assign bus.cmd_ready = !fifo_full;
   assign push_c        = bus.cmd_valid && !fifo_full;

   always_comb begin
      fifo_wdata    = '0;
      fifo_wdata.op = opcode_e'(bus.cmd_op);
      fifo_wdata.a  = bus.cmd_a;
      fifo_wdata.b  = bus.cmd_b;
   end

   alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_c),
      .wdata (fifo_wdata),
      .pop   (pop_c),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:    if (!fifo_empty) state_n = S_ISSUE;
         S_ISSUE:   state_n = S_RESPOND;
         S_RESPOND: if (bus.rsp_ready) state_n = fifo_empty ? S_IDLE : S_ISSUE;
         default:   state_n = S_IDLE;
      endcase
   end

   // Per-state strobes; rsp_valid is always set while in RESPOND
   always_comb begin
      pop_c     = 1'b0;
      capture_c = 1'b0;
      rsp_hs_c  = 1'b0;
      case (state)
         S_IDLE:    pop_c = !fifo_empty;
         S_ISSUE:   capture_c = 1'b1;
         S_RESPOND: begin
            rsp_hs_c = bus.rsp_ready;
            pop_c    = bus.rsp_ready && !fifo_empty;
         end
         default: ;
      endcase
   end

   assign occ_n = fifo_count + CW'(push_c) - CW'(pop_c);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_opcode     <= '0;
         alu_a          <= '0;
         alu_b          <= '0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_op     <= '0;
         bus.rsp_result <= '0;
         done_cnt       <= '0;
         busy           <= 1'b0;
      end else begin
         if (pop_c) begin
            alu_opcode <= fifo_rdata.op;
            alu_a      <= WIDTH'(fifo_rdata.a);
            alu_b      <= WIDTH'(fifo_rdata.b);
         end
         if (capture_c) begin
            bus.rsp_op     <= alu_opcode;
            bus.rsp_result <= CMD_WIDTH'(alu_result);
            bus.rsp_valid  <= 1'b1;
         end else if (rsp_hs_c) begin
            bus.rsp_valid  <= 1'b0;
         end
         if (rsp_hs_c) done_cnt <= done_cnt + 8'd1;
         busy <= (state_n != S_IDLE) || (occ_n != '0);
      end
   end

`ifdef ALU_CMD_ISSUER_CHECK_EN
   // Sticky flag: ALU output disagrees with the reference at the capture edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_err <= 1'b0;
      end else if (capture_c &&
                   (alu_ref(opcode_e'(alu_opcode), CMD_WIDTH'(alu_a), CMD_WIDTH'(alu_b))
                    != CMD_WIDTH'(alu_result))) begin
         chk_err <= 1'b1;
      end
   end
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a behavioural 2-bit ALU attached.
module tb_alu_cmd_issuer;

   localparam int unsigned WIDTH = 2;
   localparam int unsigned DEPTH = 4;
`ifdef ALU_CMD_ISSUER_CHECK_EN
   localparam logic EXP_CHK = 1'b1;
`else
   localparam logic EXP_CHK = 1'b0;
`endif

   typedef struct {
      logic [1:0] op;
      logic [1:0] res;
   } rsp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [1:0]       alu_opcode;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             busy;
   logic [7:0]       done_cnt;
   logic             chk_err;
   logic             bad_alu = 1'b0;

   rsp_t sb[$];
   int   hs_cyc[$];
   rsp_t mon_exp;
   int   n_checks = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   exp_done = 0;
   int   last_hs = -1;
   int   idle_cyc;
   logic [1:0] held_op;
   logic [1:0] held_res;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_cmd_issuer_if bus();

   alu_cmd_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .alu_opcode (alu_opcode),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .busy       (busy),
      .done_cnt   (done_cnt),
      .chk_err    (chk_err)
   );

   function automatic logic [1:0] exp_of(input logic [1:0] op, input logic [1:0] a,
                                         input logic [1:0] b);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return ~a;
         default: return {1'b0, |b};
      endcase
   endfunction

   // Behavioural ALU, optionally broken to exercise the result checker
   always_comb begin
      alu_result = exp_of(alu_opcode, alu_a, alu_b);
      if (bad_alu) alu_result = '0;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Response monitor: a handshake seen here completes at the next rising edge
   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
         if (sb.size() == 0) begin
            check_eq("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            mon_exp = sb.pop_front();
            check_eq("rsp_op", 32'(bus.rsp_op), 32'(mon_exp.op));
            check_eq("rsp_result", 32'(bus.rsp_result), 32'(mon_exp.res));
         end
         hs_cyc.push_back(cyc);
         last_hs = cyc;
         exp_done++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
      rsp_t e;
      bit   ok;
      ok    = 1'b0;
      e.op  = op;
      e.res = bad_alu ? 2'b00 : exp_of(op, a, b);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         if (bus.cmd_ready === 1'b1) begin
            sb.push_back(e);
            ok = 1'b1;
         end
      end
      if (ok) tick(1);
      bus.cmd_valid = 1'b0;
      if (!ok) check_eq("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain(input int max, output int when);
      when = -1;
      for (int t = 0; t < max; t++) begin
         @(negedge clk);
         if (sb.size() == 0 && busy === 1'b0) begin
            when = cyc;
            break;
         end
      end
      if (when < 0) check_eq("drain_timeout", 32'd0, 32'd1);
      tick(1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
      check_eq({tag, "_alu_opcode"}, 32'(alu_opcode), 32'd0);
      check_eq({tag, "_alu_a"}, 32'(alu_a), 32'd0);
      check_eq({tag, "_alu_b"}, 32'(alu_b), 32'd0);
      check_eq({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      check_eq({tag, "_rsp_op"}, 32'(bus.rsp_op), 32'd0);
      check_eq({tag, "_rsp_result"}, 32'(bus.rsp_result), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd0);
      check_eq({tag, "_chk_err"}, 32'(chk_err), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'd0;
      bus.cmd_a     = 2'd0;
      bus.cmd_b     = 2'd0;
      bus.rsp_ready = 1'b0;
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);

      // Single ADD: latency to alu_* and to rsp_valid
      bus.rsp_ready = 1'b1;
      send(2'd0, 2'd1, 2'd2);
      check_eq("lat_rsp_valid_k", 32'(bus.rsp_valid), 32'd0);
      tick(1);
      check_eq("lat_alu_opcode", 32'(alu_opcode), 32'd0);
      check_eq("lat_alu_a", 32'(alu_a), 32'd1);
      check_eq("lat_alu_b", 32'(alu_b), 32'd2);
      check_eq("lat_rsp_valid_k1", 32'(bus.rsp_valid), 32'd0);
      check_eq("lat_busy", 32'(busy), 32'd1);
      tick(1);
      check_eq("lat_rsp_valid_k2", 32'(bus.rsp_valid), 32'd1);
      check_eq("lat_rsp_op", 32'(bus.rsp_op), 32'd0);
      check_eq("lat_rsp_result", 32'(bus.rsp_result), 32'd3);
      drain(50, idle_cyc);
      check_eq("done_after_add", 32'(done_cnt), 32'd1);

      // Each opcode, including wrap and reduction corner cases
      send(2'd1, 2'd0, 2'd1);
      send(2'd2, 2'd1, 2'd0);
      send(2'd3, 2'd0, 2'd2);
      send(2'd3, 2'd3, 2'd0);
      drain(100, idle_cyc);
      check_eq("done_after_ops", 32'(done_cnt), 32'(exp_done % 256));

      // Back-pressure: five accepted, sixth refused, first response held
      bus.rsp_ready = 1'b0;
      send(2'd0, 2'd3, 2'd3);
      send(2'd1, 2'd1, 2'd3);
      send(2'd2, 2'd0, 2'd1);
      send(2'd3, 2'd2, 2'd1);
      send(2'd0, 2'd2, 2'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'd2;
      bus.cmd_a     = 2'd3;
      bus.cmd_b     = 2'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      end
      tick(1);
      bus.cmd_valid = 1'b0;
      check_eq("held_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("held_rsp_op", 32'(bus.rsp_op), 32'd0);
      check_eq("held_rsp_result", 32'(bus.rsp_result), 32'd2);
      held_op  = bus.rsp_op;
      held_res = bus.rsp_result;
      tick(3);
      check_eq("stable_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("stable_rsp_op", 32'(bus.rsp_op), 32'(held_op));
      check_eq("stable_rsp_result", 32'(bus.rsp_result), 32'(held_res));
      hs_cyc.delete();
      bus.rsp_ready = 1'b1;
      drain(100, idle_cyc);
      check_eq("bp_rsp_count", 32'(hs_cyc.size()), 32'd5);
      for (int i = 1; i < hs_cyc.size(); i++)
         check_eq("rsp_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);
      check_eq("done_after_bp", 32'(done_cnt), 32'(exp_done % 256));

      // Stream until done_cnt wraps to zero
      begin
         int n;
         n = 256 - (exp_done % 256);
         for (int i = 0; i < n; i++)
            send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end
      drain(2000, idle_cyc);
      check_eq("wrap_done_cnt", 32'(done_cnt), 32'd0);
      check_eq("busy_drop_cycle", 32'(idle_cyc), 32'(last_hs + 1));
      check_eq("chk_err_clean", 32'(chk_err), 32'd0);

      // Reset while responding with three commands queued
      bus.rsp_ready = 1'b0;
      send(2'd0, 2'd1, 2'd1);
      send(2'd1, 2'd2, 2'd1);
      send(2'd2, 2'd2, 2'd0);
      send(2'd3, 2'd0, 2'd3);
      tick(2);
      check_eq("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      sb.delete();
      exp_done = 0;
      tick(2);
      @(negedge clk);
      rst_n = 1'b1;
      bus.rsp_ready = 1'b1;
      tick(10);
      check_eq("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("post_rst_busy", 32'(busy), 32'd0);
      check_eq("post_rst_done", 32'(done_cnt), 32'd0);
      send(2'd0, 2'd2, 2'd3);
      drain(50, idle_cyc);
      check_eq("post_rst_one", 32'(done_cnt), 32'd1);

      // Broken ALU result: checker flag is sticky when compiled in
      bad_alu = 1'b1;
      send(2'd0, 2'd1, 2'd1);
      drain(50, idle_cyc);
      bad_alu = 1'b0;
      check_eq("chk_err_set", 32'(chk_err), 32'(EXP_CHK));
      send(2'd1, 2'd3, 2'd1);
      drain(50, idle_cyc);
      check_eq("chk_err_sticky", 32'(chk_err), 32'(EXP_CHK));
      check_eq("done_final", 32'(done_cnt), 32'(exp_done % 256));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-side front end for the 2-bit combinational ALU. Accepts operation requests over a valid/ready channel and buffers them in a small FIFO. Issues them one at a time on registered opcode/A/B lines into the ALU, captures the ALU result, and returns it over a valid/ready response channel in request order.

## Interface
- WIDTH, 2: operand and result width; must match the ALU.
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- clk  input  1  sole clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  request present.
- cmd_ready  output  1  FIFO not full; a handshake occurs when cmd_valid && cmd_ready.
- cmd_op  input  2  opcode: ADD=0, SUB=1, INV=2, RED_OR=3.
- cmd_a  input  WIDTH  operand A.
- cmd_b  input  WIDTH  operand B.
- alu_opcode  output  2  registered opcode to the ALU.
- alu_a  output  WIDTH  registered A to the ALU.
- alu_b  output  WIDTH  registered B to the ALU.
- alu_result  input  WIDTH  combinational ALU output.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_op  output  2  opcode of the returned operation.
- rsp_result  output  WIDTH  captured result.
- busy  output  1  high when the FIFO is non-empty or state ≠ IDLE.
- done_cnt  output  8  count of completed response handshakes; wraps 255→0.
- chk_err  output  1  sticky result-mismatch flag; see Configuration.

## Operation
- The FIFO is written on each cmd handshake. cmd_ready = !full, computed combinationally from the occupancy count.
- When the FIFO is full, cmd_ready is 0 even if a pop occurs in the same cycle. No bypass path exists.
- FSM states: IDLE, ISSUE, RESPOND.
  - IDLE: if the FIFO is non-empty, pop the head into the alu_* registers and go to ISSUE.
  - ISSUE: the ALU settles combinationally. At the edge, alu_result goes into rsp_result and alu_opcode goes into rsp_op. Set rsp_valid and go to RESPOND.
  - RESPOND: hold rsp_* stable while rsp_valid && !rsp_ready. On handshake, increment done_cnt. Then, if the FIFO is non-empty, pop the next entry into alu_* and go to ISSUE; otherwise go to IDLE and clear rsp_valid.
- The alu_* registers hold their last values in IDLE and RESPOND. They change only on a pop.
- Responses return in FIFO order. No command is dropped or duplicated.
- Results are taken from alu_result as-is. The expected values are:
  - ADD: (A+B) mod 2^WIDTH.
  - SUB: (A−B) mod 2^WIDTH.
  - INV: ~A.
  - RED_OR: zero-extended |B.

## Timing
- Reset values: cmd_ready=1, alu_opcode=0, alu_a=0, alu_b=0, rsp_valid=0, rsp_op=0, rsp_result=0, busy=0, done_cnt=0, chk_err=0. FIFO empty; state IDLE.
- Latency: a cmd handshake at edge k into an empty, idle block gives alu_* valid after edge k+1 and rsp_valid=1 after edge k+2.
- Throughput with rsp_ready held at 1: one response every 2 cycles (ISSUE, RESPOND).
- A push and a pop in the same cycle on a non-full FIFO leave occupancy unchanged.
- FIFO pointers wrap modulo DEPTH; the occupancy counter is log2(DEPTH)+1 bits.
- Reset asserted mid-operation immediately discards queued commands and any pending response. All outputs return to their reset values asynchronously.

## Configuration
- Macro: ALU_CMD_ISSUER_CHECK_EN.
- Defined: an internal reference model computes the expected result from alu_opcode/alu_a/alu_b in ISSUE. A mismatch with alu_result at the ISSUE→RESPOND edge sets chk_err, which stays set until reset.
- Undefined: the model is not compiled and chk_err is tied to 0.
- Port list is identical in both builds.

## Structure
- Shared package alu_pkg holds:
  - opcode_e (ADD/SUB/INV/RED_OR, logic [1:0]);
  - the issuer state enum;
  - a packed cmd_t struct {op, a, b} parameterised by a package WIDTH constant of 2.
- Sub-module alu_cmd_fifo: synchronous FIFO of cmd_t, DEPTH entries, with push/pop/full/empty/count.
- The top module holds the FSM, the alu_* and rsp_* registers, done_cnt, and the check logic.

## Test plan
- ADD a=1,b=2 with rsp_ready=1: rsp_valid 2 cycles after the cmd handshake; rsp_op=0, rsp_result=3, done_cnt=1.
- SUB a=0,b=1 → rsp_result=3 (wrap); INV a=1 → 2; RED_OR b=2 → 1; RED_OR b=0 → 0.
- rsp_ready=0 and push 6 commands (DEPTH=4): 5 accepted, cmd_ready=0 on the 6th, first response held stable. Then rsp_ready=1: 5 responses in push order, 2 cycles apart, done_cnt=5.
- 256 back-to-back commands with rsp_ready=1: done_cnt wraps to 0; busy drops 1 cycle after the last response handshake.
- Assert rst_n=0 while in RESPOND with 3 queued commands: all outputs at reset values immediately. After release, no stale responses appear.
- ALU_CMD_ISSUER_CHECK_EN defined, alu_result forced to 0 for ADD a=1,b=1: chk_err=1 after ISSUE and remains 1. Macro undefined, same stimulus: chk_err=0.
